// File: rtl/als_error_monitor.sv
// als_error_monitor: windowed error statistics for a WIDTH-bit approximate adder.
// Accepts (in0, in1, out0) samples, recomputes the exact sum and accumulates
// error count, error-distance sum and maximum error distance over num_samples.
// Optional macro ALS_ERR_BIAS_EN adds a saturating signed error-bias accumulator;
// without it err_bias is tied to 0.
module als_error_monitor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 20,
    parameter int unsigned ACC_W = 38
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               valid_in,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH:0]     out0,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ACC_W-1:0]   ed_sum,
    output logic [WIDTH:0]     ed_max,
    output logic [ACC_W-1:0]   err_bias
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned DW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      num_q;
    logic [CNT_W-1:0]      acc_q;
    logic                  accept_c;

    logic [SW-1:0]         exact_c;
    logic signed [DW-1:0]  diff_c;
    logic [SW-1:0]         ed_c;

    logic                  s1_valid_q;
    logic                  s1_last_q;
    logic                  s1_mis_q;
    logic [SW-1:0]         s1_ed_q;

    logic [ACC_W:0]        sum_c;

    // A sample is taken only while running, inside the window, and not on a restart edge
    assign accept_c = (state_q == RUN) && valid_in && (acc_q < num_q) && !start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start restarts the window from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (start)                                    state_d = RUN;
                else if ((num_q == '0) || (s1_valid_q && s1_last_q)) state_d = DONE;
            end
            DONE: state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Exact sum, signed difference and its magnitude for the presented sample
    always_comb begin
        exact_c = SW'(in0) + SW'(in1);
        diff_c  = $signed({1'b0, out0}) - $signed({1'b0, exact_c});
        ed_c    = diff_c[DW-1] ? SW'(-diff_c) : diff_c[SW-1:0];
        sum_c   = {1'b0, ed_sum} + (ACC_W+1)'(s1_ed_q);
    end

    // Stage 1: window bookkeeping and per-sample error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q      <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mis_q   <= 1'b0;
            s1_ed_q    <= '0;
        end else if (start) begin
            num_q      <= num_samples;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                acc_q     <= acc_q + CNT_W'(1);
                s1_last_q <= ((acc_q + CNT_W'(1)) == num_q);
                s1_mis_q  <= (out0 != exact_c);
                s1_ed_q   <= ed_c;
            end
        end
    end

    // Stage 2: saturating accumulators, which are also the outputs
    always_ff @(posedge clk) begin
        if (rst || start) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
        end else if (s1_valid_q) begin
            if (sample_cnt != '1)           sample_cnt <= sample_cnt + CNT_W'(1);
            if (s1_mis_q && (err_cnt != '1)) err_cnt    <= err_cnt + CNT_W'(1);
            ed_sum <= sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
            if (s1_ed_q > ed_max)           ed_max     <= s1_ed_q;
        end
    end

`ifdef ALS_ERR_BIAS_EN
    logic signed [DW-1:0]    s1_diff_q;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W:0]   bias_sum_c;

    assign bias_sum_c = $signed({bias_q[ACC_W-1], bias_q}) + (ACC_W+1)'(s1_diff_q);
    assign err_bias   = bias_q;

    // Signed difference capture alongside stage 1
    always_ff @(posedge clk) begin
        if (rst)                          s1_diff_q <= '0;
        else if (!start && accept_c)      s1_diff_q <= diff_c;
    end

    // Two's-complement bias accumulator, saturating at the signed limits
    always_ff @(posedge clk) begin
        if (rst || start) begin
            bias_q <= '0;
        end else if (s1_valid_q) begin
            if (bias_sum_c[ACC_W] != bias_sum_c[ACC_W-1])
                bias_q <= bias_sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}};
            else
                bias_q <= bias_sum_c[ACC_W-1:0];
        end
    end
`else
    assign err_bias = '0;
`endif

endmodule
